// File: rtl/complement_pipe.sv
// complement_pipe: two-stage, LANES-wide sign/complement converter.
//   mode 0: sign-magnitude (with external per-lane sign) -> two's complement
//   mode 1: two's complement -> sign-magnitude (sign reported on out_sign)
// Stage 1 captures the beat plus per-lane zero/sign-combine flags; stage 2 is
// the output register holding the converted lanes. Valid/ready with full
// backpressure, one beat per cycle when the consumer keeps up.
// Optional feature macro: COMPLEMENT_SAT_EN -- saturate the mode-1 magnitude
// of the most-negative input to all-ones and flag it on out_sat; without it
// that magnitude wraps to zero and out_sat stays 0.
module complement_pipe #(
  parameter int LANES = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_mode,
  input  logic [LANES-1:0]       in_sign,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_sign,
  output logic [LANES-1:0]       out_zero,
  output logic [LANES-1:0]       out_sat
);

  localparam int DW = LANES * WIDTH;

  // Pipeline advance strobes
  logic s2_adv;
  logic s1_adv;

  // Stage 1 registers
  logic             s1_valid_q, s1_valid_d;
  logic             s1_mode_q,  s1_mode_d;
  logic [DW-1:0]    s1_data_q,  s1_data_d;
  logic [LANES-1:0] s1_zero_q,  s1_zero_d;
  logic [LANES-1:0] s1_c_q,     s1_c_d;

  // Stage 2 (output) registers
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q,  out_data_d;
  logic [LANES-1:0] out_sign_q,  out_sign_d;
  logic [LANES-1:0] out_zero_q,  out_zero_d;
  logic [LANES-1:0] out_sat_q,   out_sat_d;

  // Per-lane combinational results
  logic [LANES-1:0] in_zero;
  logic [LANES-1:0] in_c;
  logic [DW-1:0]    cv_data;
  logic [LANES-1:0] cv_sign;
  logic [LANES-1:0] cv_sat;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [WIDTH-1:0] in_lane;
      logic [WIDTH-1:0] x;
      logic [WIDTH-2:0] neg_low;
      logic [WIDTH-1:0] lane_out;
      logic             lane_sign;
      logic             lane_sat;

      // Stage-1 flags: all-zero lane, and external sign combined with lane MSB
      assign in_lane     = in_data[gi*WIDTH +: WIDTH];
      assign in_zero[gi] = (in_lane == '0);
      assign in_c[gi]    = in_sign[gi] ^ in_lane[WIDTH-1];

      // Low WIDTH-1 bits of the negation serve both directions: in mode 0 it
      // is the complement of the magnitude, in mode 1 the magnitude of a
      // negative word.
      assign x       = s1_data_q[gi*WIDTH +: WIDTH];
      assign neg_low = ~x[WIDTH-2:0] + {{(WIDTH-2){1'b0}}, 1'b1};

      // Convert one held lane according to the beat's sampled mode
      always_comb begin
        lane_out  = '0;
        lane_sign = 1'b0;
        lane_sat  = 1'b0;
        if (!s1_zero_q[gi]) begin
          lane_sign = s1_c_q[gi];
          if (!s1_mode_q) begin
            lane_out = {s1_c_q[gi], s1_c_q[gi] ? neg_low : x[WIDTH-2:0]};
          end else begin
            lane_out = {1'b0, x[WIDTH-1] ? neg_low : x[WIDTH-2:0]};
`ifdef COMPLEMENT_SAT_EN
            // Most-negative word has no representable magnitude: clamp it
            if (x[WIDTH-1] && (x[WIDTH-2:0] == '0)) begin
              lane_out = {1'b0, {(WIDTH-1){1'b1}}};
              lane_sat = 1'b1;
            end
`endif
          end
        end
      end

      assign cv_data[gi*WIDTH +: WIDTH] = lane_out;
      assign cv_sign[gi]                = lane_sign;
      assign cv_sat[gi]                 = lane_sat;
    end
  endgenerate

  // Flow control: a stage advances when it is empty or its successor advances
  assign s2_adv   = !out_valid_q | out_ready;
  assign s1_adv   = !s1_valid_q | s2_adv;
  assign in_ready = rst_n & s1_adv;

  // Next-state for both stages; each holds unless its stage advances
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_mode_d   = s1_mode_q;
    s1_data_d   = s1_data_q;
    s1_zero_d   = s1_zero_q;
    s1_c_d      = s1_c_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sign_d  = out_sign_q;
    out_zero_d  = out_zero_q;
    out_sat_d   = out_sat_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_mode_d = in_mode;
        s1_data_d = in_data;
        s1_zero_d = in_zero;
        s1_c_d    = in_c;
      end
    end

    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = cv_data;
        out_sign_d = cv_sign;
        out_zero_d = s1_zero_q;
        out_sat_d  = cv_sat;
      end
    end
  end

  // State registers; reset discards any in-flight beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= 1'b0;
      s1_data_q   <= '0;
      s1_zero_q   <= '0;
      s1_c_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sign_q  <= '0;
      out_zero_q  <= '0;
      out_sat_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mode_q   <= s1_mode_d;
      s1_data_q   <= s1_data_d;
      s1_zero_q   <= s1_zero_d;
      s1_c_q      <= s1_c_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sign_q  <= out_sign_d;
      out_zero_q  <= out_zero_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sign  = out_sign_q;
  assign out_zero  = out_zero_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_complement_pipe.sv
// tb_complement_pipe: directed and streaming checks of complement_pipe
// (LANES=4, WIDTH=16). Honours COMPLEMENT_SAT_EN for the saturation cases.
module tb_complement_pipe;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  sign;
    logic [3:0]  zero;
    logic [3:0]  sat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic [3:0]  in_sign;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  out_sign;
  logic [3:0]  out_zero;
  logic [3:0]  out_sat;

  int   n_vec;
  int   n_err;
  int   rx_cnt;
  exp_t exp_q[$];
  exp_t mon_e;
  logic        stall_prev;
  logic [63:0] stall_data;
  logic [3:0]  stall_sign;
  logic        t6_done;

  complement_pipe #(.LANES(4), .WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_sign   (in_sign),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sign  (out_sign),
    .out_zero  (out_zero),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [63:0] d, input logic [3:0] s,
                                  input logic [3:0] z, input logic [3:0] t);
    exp_t r;
    r.data = d; r.sign = s; r.zero = z; r.sat = t;
    return r;
  endfunction

  // Arithmetic reference: works on integer values rather than bit tricks
  function automatic exp_t model(input logic mode, input logic [3:0] sign, input logic [63:0] data);
    exp_t        r;
    logic [15:0] x;
    logic [15:0] lane;
    logic        c;
    int          lo;
    int          sv;
    int          a;
    r.data = '0; r.sign = '0; r.zero = '0; r.sat = '0;
    for (int i = 0; i < 4; i++) begin
      x    = data[16*i +: 16];
      lo   = int'(x[14:0]);
      c    = sign[i] ^ x[15];
      lane = 16'h0000;
      if (x == 16'h0000) begin
        r.zero[i] = 1'b1;
      end else if (!mode) begin
        if (c) lane = 16'h8000 | 16'((32768 - lo) % 32768);
        else   lane = 16'(lo);
        r.sign[i] = lane[15];
      end else begin
        sv = int'($signed(x));
        a  = (sv < 0) ? -sv : sv;
        r.sign[i] = c;
        if (a == 32768) begin
`ifdef COMPLEMENT_SAT_EN
          lane     = 16'h7FFF;
          r.sat[i] = 1'b1;
`else
          lane = 16'h0000;
`endif
        end else begin
          lane = 16'(a);
        end
      end
      r.data[16*i +: 16] = lane;
    end
    return r;
  endfunction

  function automatic logic [15:0] rnd_lane();
    int k;
    k = $urandom_range(0, 3);
    if (k == 0) return 16'h0000;
    if (k == 1) return 16'h8000;
    return 16'($urandom);
  endfunction

  function automatic logic [63:0] rnd_data();
    return {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()};
  endfunction

  // Present one beat from posedge+1; returns at posedge+1 after acceptance
  task automatic send_beat(input logic mode, input logic [3:0] sign, input logic [63:0] data,
                           input exp_t e, output int waits);
    logic done;
    waits = 0;
    done  = 1'b0;
    in_valid = 1'b1;
    in_mode  = mode;
    in_sign  = sign;
    in_data  = data;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check_val("send_timeout", 64'(waits), 64'd0);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    check_val("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Output monitor: scoreboard compare on every transfer, stability while stalled
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && out_valid) begin
        check_val("stall_data", out_data, stall_data);
        check_val("stall_sign", 64'(out_sign), 64'(stall_sign));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_beat", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_val($sformatf("data#%0d", rx_cnt), out_data, mon_e.data);
          check_val($sformatf("sign#%0d", rx_cnt), 64'(out_sign), 64'(mon_e.sign));
          check_val($sformatf("zero#%0d", rx_cnt), 64'(out_zero), 64'(mon_e.zero));
          check_val($sformatf("sat#%0d", rx_cnt), 64'(out_sat), 64'(mon_e.sat));
        end
        $display("beat %0d: data=%h sign=%b zero=%b sat=%b", rx_cnt, out_data, out_sign, out_zero, out_sat);
        rx_cnt++;
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      stall_sign = out_sign;
    end
  end

  initial begin
    int   w;
    int   tot_w;
    int   rx0;
    logic m;
    logic [3:0]  s;
    logic [63:0] d;

    n_vec = 0; n_err = 0; rx_cnt = 0;
    stall_prev = 1'b0; stall_data = '0; stall_sign = '0; t6_done = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_sign = '0; in_data = '0; out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready", 64'(in_ready), 64'd0);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_out_data", out_data, 64'd0);
    check_val("rst_out_sign", 64'(out_sign), 64'd0);
    check_val("rst_out_zero", 64'(out_zero), 64'd0);
    check_val("rst_out_sat", 64'(out_sat), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_val("rel_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Mode 0 directed beat plus latency
    send_beat(1'b0, 4'b1101, 64'h0000_8005_8005_0005,
              mk_exp(64'h0000_0005_FFFB_FFFB, 4'b0011, 4'b1000, 4'b0000), w);
    in_valid = 1'b0;
    check_val("lat_cycle1", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check_val("lat_cycle2", 64'(out_valid), 64'd1);
    wait_drain();

    // Mode 1 directed beat including the most-negative lane
`ifdef COMPLEMENT_SAT_EN
    send_beat(1'b1, 4'b0010, 64'h8000_0000_0005_FFFB,
              mk_exp(64'h7FFF_0000_0005_0005, 4'b1011, 4'b0100, 4'b1000), w);
`else
    send_beat(1'b1, 4'b0010, 64'h8000_0000_0005_FFFB,
              mk_exp(64'h0000_0000_0005_0005, 4'b1011, 4'b0100, 4'b0000), w);
`endif
    in_valid = 1'b0;
    wait_drain();

    // Backpressure: 8 alternating-mode beats, out_ready toggling then held low
    fork
      begin
        for (int b = 0; b < 8; b++) begin
          m = b[0];
          s = 4'(b * 5);
          d = {16'h8000 ^ 16'(b), 16'(b), 16'(16'hFFF0 + b), 16'(256 * b)};
          send_beat(m, s, d, model(m, s, d), w);
        end
        in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 6; k++) begin
          out_ready = (k % 2 == 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b0;
        repeat (4) begin
          @(posedge clk);
          #1;
        end
        @(negedge clk);
        check_val("bp_in_ready_low", 64'(in_ready), 64'd0);
        check_val("bp_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    // Full-rate streaming: 32 back-to-back beats
    out_ready = 1'b1;
    rx0   = rx_cnt;
    tot_w = 0;
    for (int b = 0; b < 32; b++) begin
      m = 1'($urandom_range(0, 1));
      s = 4'($urandom);
      d = rnd_data();
      send_beat(m, s, d, model(m, s, d), w);
      tot_w += w;
    end
    in_valid = 1'b0;
    check_val("stream_stalls", 64'(tot_w), 64'd0);
    check_val("stream_rx_early", 64'(rx_cnt - rx0), 64'd30);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check_val("stream_rx_all", 64'(rx_cnt - rx0), 64'd32);
    wait_drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    send_beat(1'b0, 4'b0001, 64'h1111_2222_3333_4444, model(1'b0, 4'b0001, 64'h1111_2222_3333_4444), w);
    send_beat(1'b1, 4'b0000, 64'hFFFF_0001_8000_0000, model(1'b1, 4'b0000, 64'hFFFF_0001_8000_0000), w);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check_val("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check_val("mid_rst_out_data", out_data, 64'd0);
    check_val("mid_rst_in_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    rx0 = rx_cnt;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_val("post_rst_no_stale", 64'(rx_cnt - rx0), 64'd0);
    check_val("post_rst_out_valid", 64'(out_valid), 64'd0);
    send_beat(1'b0, 4'b0000, 64'h7FFF_8001_0000_0003,
              mk_exp(64'h7FFF_FFFF_0000_0003, 4'b0100, 4'b0010, 4'b0000), w);
    in_valid = 1'b0;
    wait_drain();

    // Random traffic with random backpressure against the model
    fork
      begin
        for (int b = 0; b < 1000; b++) begin
          m = 1'($urandom_range(0, 1));
          s = 4'($urandom);
          d = rnd_data();
          send_beat(m, s, d, model(m, s, d), w);
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
        end
        in_valid = 1'b0;
        t6_done = 1'b1;
      end
      begin
        while (!t6_done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
